// File: rtl/ccm_feeder_pkg.sv
// ccm_feeder_pkg: shared CCM sizes, feeder FSM encoding and the
// issue-counter status bundle.
package ccm_feeder_pkg;

  localparam int CCM_PEA_NUM  = 4;
  localparam int CCM_SRAM_NUM = 32;
  localparam int W_LANE       = 72;
  localparam int FM_AW        = 18;
  localparam int CNT_W        = 9;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_W = 3'd1;
  localparam logic [2:0] S_WAIT_W = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  typedef struct packed {
    logic pad_col;
    logic top_row;
    logic bot_row;
    logic last;
  } cnt_flags_t;

  // word address of padded column c in row r (c = 0 wraps, caller gates it)
  function automatic logic [FM_AW-1:0] fm_word(
    input logic [CNT_W-1:0] r,
    input logic [CNT_W-1:0] c,
    input logic [CNT_W-1:0] w
  );
    return FM_AW'(r) * FM_AW'(w) + FM_AW'(c) - FM_AW'(1);
  endfunction

endpackage

// File: rtl/ccm_feeder_cnt.sv
// ccm_feeder_cnt: padded column / row issue counter with the
// padding and end-of-frame flags derived from it.
module ccm_feeder_cnt
  import ccm_feeder_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  output logic [CNT_W-1:0] c,
  output logic [CNT_W-1:0] r,
  output cnt_flags_t       flags
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(IMG_W + 1);
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] c_d, c_q;
  logic [CNT_W-1:0] r_d, r_q;
  logic             c_wrap;

  assign c_wrap = (c_q == C_LAST);

  always_comb begin
    c_d = c_q;
    r_d = r_q;
    if (clr) begin
      c_d = '0;
      r_d = '0;
    end else if (adv) begin
      if (c_wrap) begin
        c_d = '0;
        r_d = r_q + ONE;
      end else begin
        c_d = c_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= '0;
      r_q <= '0;
    end else begin
      c_q <= c_d;
      r_q <= r_d;
    end
  end

  assign c             = c_q;
  assign r             = r_q;
  assign flags.pad_col = (c_q == '0) || c_wrap;
  assign flags.top_row = (r_q == '0);
  assign flags.bot_row = (r_q == R_LAST);
  assign flags.last    = c_wrap && (r_q == R_LAST);

endmodule

// File: rtl/ccm_feeder.sv
// ccm_feeder: loads one weight word, then streams padded 3-row
// feature columns to the CCM array, one column per ready cycle.
module ccm_feeder
  import ccm_feeder_pkg::*;
#(
  parameter int PEA_num   = CCM_PEA_NUM,
  parameter int SRAM_NUM  = CCM_SRAM_NUM,
  parameter int IMG_W     = 64,
  parameter int IMG_H     = 64,
  parameter int DRAIN_CYC = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     ready,
  output logic                     w_rd_en,
  input  logic [SRAM_NUM*72-1:0]   w_rdata,
  output logic                     fm_rd_en,
  output logic [17:0]              fm_addr1,
  output logic [17:0]              fm_addr2,
  output logic [17:0]              fm_addr3,
  input  logic [PEA_num*8-1:0]     fm_rdata1,
  input  logic [PEA_num*8-1:0]     fm_rdata2,
  input  logic [PEA_num*8-1:0]     fm_rdata3,
  output logic [PEA_num*8-1:0]     Data1,
  output logic [PEA_num*8-1:0]     Data2,
  output logic [PEA_num*8-1:0]     Data3,
  output logic [SRAM_NUM*72-1:0]   Weight,
  output logic                     Weight_en,
  output logic                     en,
  output logic [8:0]               col,
  output logic [8:0]               row,
  output logic                     busy,
  output logic                     done
);

  localparam int          WW         = SRAM_NUM * W_LANE;
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYC - 1);

  logic [2:0]       state_d, state_q;
  logic [15:0]      dcnt_d, dcnt_q;
  logic             st_idle, st_load, st_wait, st_stream, st_done;
  logic             issue, inner;
  logic [CNT_W-1:0] c, r;
  cnt_flags_t       flags;
  logic [FM_AW-1:0] base;

  logic             en_d, en_q;
  logic [CNT_W-1:0] col_d, col_q, row_d, row_q;
  logic             v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
  logic [WW-1:0]    wgt_d, wgt_q;
  logic             wen_d, wen_q;

  assign st_idle   = (state_q == S_IDLE);
  assign st_load   = (state_q == S_LOAD_W);
  assign st_wait   = (state_q == S_WAIT_W);
  assign st_stream = (state_q == S_STREAM);
  assign st_done   = (state_q == S_DONE);
  assign issue     = st_stream & ready;

  ccm_feeder_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (~st_stream),
    .adv   (issue),
    .c     (c),
    .r     (r),
    .flags (flags)
  );

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_LOAD_W;
      S_LOAD_W: state_d = S_WAIT_W;
      S_WAIT_W: state_d = S_STREAM;
      S_STREAM: begin
        if (issue && flags.last) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DRAIN_LAST) state_d = S_DONE;
        else dcnt_d = dcnt_q + 16'd1;
      end
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // reads follow the counter, so a stalled column keeps its read alive
  assign inner    = st_stream & ~flags.pad_col;
  assign base     = fm_word(r, c, CNT_W'(IMG_W));
  assign fm_rd_en = inner;
  assign fm_addr2 = inner ? base : '0;
  assign fm_addr1 = inner ? base - FM_AW'(IMG_W) : '0;
  assign fm_addr3 = inner ? base + FM_AW'(IMG_W) : '0;
  assign w_rd_en  = st_load;

  always_comb begin
    en_d  = issue;
    col_d = issue ? c : col_q;
    row_d = issue ? r : row_q;
    v1_d  = issue & ~flags.pad_col & ~flags.top_row;
    v2_d  = issue & ~flags.pad_col;
    v3_d  = issue & ~flags.pad_col & ~flags.bot_row;
    wgt_d = st_wait ? w_rdata : wgt_q;
    wen_d = st_wait;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dcnt_q  <= '0;
      en_q    <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      wgt_q   <= '0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      en_q    <= en_d;
      col_q   <= col_d;
      row_q   <= row_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      wgt_q   <= wgt_d;
      wen_q   <= wen_d;
    end
  end

  // SRAM words land one cycle after the read, alongside en
  assign Data1     = v1_q ? fm_rdata1 : '0;
  assign Data2     = v2_q ? fm_rdata2 : '0;
  assign Data3     = v3_q ? fm_rdata3 : '0;
  assign Weight    = wgt_q;
  assign Weight_en = wen_q;
  assign en        = en_q;
  assign col       = col_q;
  assign row       = row_q;
  assign busy      = ~st_idle;
  assign done      = st_done;

endmodule

// File: tb/tb_ccm_feeder.sv
// tb_ccm_feeder: random-ready frames on a 4x3 feeder plus a 1x1
// feeder, scored against a queue of expected padded columns.
module tb_ccm_feeder;

  localparam int PN = 4;
  localparam int SN = 32;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int DC = 4;
  localparam int DW = PN * 8;
  localparam int WW = SN * 72;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, ready;
  logic          w_rd_en;
  logic [WW-1:0] w_rdata;
  logic          fm_rd_en;
  logic [17:0]   fm_addr1, fm_addr2, fm_addr3;
  logic [DW-1:0] fm_rdata1, fm_rdata2, fm_rdata3;
  logic [DW-1:0] Data1, Data2, Data3;
  logic [WW-1:0] Weight;
  logic          Weight_en, en, busy, done;
  logic [8:0]    col, row;

  logic          t_rst, t_start;
  logic          t_w_rd_en;
  logic [WW-1:0] t_w_rdata;
  logic          t_fm_rd_en;
  logic [17:0]   t_a1, t_a2, t_a3;
  logic [DW-1:0] t_r1, t_r2, t_r3;
  logic [DW-1:0] t_d1, t_d2, t_d3;
  logic [WW-1:0] t_weight;
  logic          t_wen, t_en, t_busy, t_done;
  logic [8:0]    t_col, t_row;

  ccm_feeder #(
    .PEA_num(PN), .SRAM_NUM(SN), .IMG_W(W), .IMG_H(H), .DRAIN_CYC(DC)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .w_rd_en(w_rd_en), .w_rdata(w_rdata),
    .fm_rd_en(fm_rd_en),
    .fm_addr1(fm_addr1), .fm_addr2(fm_addr2), .fm_addr3(fm_addr3),
    .fm_rdata1(fm_rdata1), .fm_rdata2(fm_rdata2), .fm_rdata3(fm_rdata3),
    .Data1(Data1), .Data2(Data2), .Data3(Data3),
    .Weight(Weight), .Weight_en(Weight_en),
    .en(en), .col(col), .row(row), .busy(busy), .done(done)
  );

  ccm_feeder #(
    .PEA_num(PN), .SRAM_NUM(SN), .IMG_W(1), .IMG_H(1), .DRAIN_CYC(DC)
  ) u_dut1 (
    .clk(clk), .rst(t_rst), .start(t_start), .ready(1'b1),
    .w_rd_en(t_w_rd_en), .w_rdata(t_w_rdata),
    .fm_rd_en(t_fm_rd_en),
    .fm_addr1(t_a1), .fm_addr2(t_a2), .fm_addr3(t_a3),
    .fm_rdata1(t_r1), .fm_rdata2(t_r2), .fm_rdata3(t_r3),
    .Data1(t_d1), .Data2(t_d2), .Data3(t_d3),
    .Weight(t_weight), .Weight_en(t_wen),
    .en(t_en), .col(t_col), .row(t_row), .busy(t_busy), .done(t_done)
  );

  // memories: feature word = address + 1, weight word = w_mem
  logic [WW-1:0] w_mem;

  function automatic logic [DW-1:0] word(input logic [17:0] a);
    return DW'(a) + DW'(1);
  endfunction

  always @(posedge clk) begin
    if (w_rd_en) w_rdata <= w_mem;
    if (fm_rd_en) begin
      fm_rdata1 <= word(fm_addr1);
      fm_rdata2 <= word(fm_addr2);
      fm_rdata3 <= word(fm_addr3);
    end
    if (t_fm_rd_en) begin
      t_r1 <= word(t_a1);
      t_r2 <= word(t_a2);
      t_r3 <= word(t_a3);
    end
  end

  assign t_w_rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // reference: pixel seen at padded column cc of image row rr
  function automatic logic [DW-1:0] px(input int rr, input int cc,
                                       input int w, input int h);
    if (rr < 0 || rr >= h || cc < 1 || cc > w) return '0;
    return DW'(rr * w + cc);
  endfunction

  typedef struct packed {
    logic [8:0]    col;
    logic [8:0]    row;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [DW-1:0] d3;
  } beat_t;

  beat_t exp_q[$];

  task automatic push_frame();
    beat_t b;
    for (int rr = 0; rr < H; rr++)
      for (int cc = 0; cc < W + 2; cc++) begin
        b.col = 9'(cc);
        b.row = 9'(rr);
        b.d1  = px(rr - 1, cc, W, H);
        b.d2  = px(rr, cc, W, H);
        b.d3  = px(rr + 1, cc, W, H);
        exp_q.push_back(b);
      end
  endtask

  int            cyc_n = 0, s_cyc = 0, last_cyc = 0;
  int            en_cnt = 0, done_cnt = 0;
  bit            frame_on = 0, prev_rd = 0, t_fin = 0;
  logic [WW-1:0] w_exp = '0;

  initial forever begin
    beat_t b;
    @(negedge clk);
    cyc_n++;
    if (rst) begin
      exp_q.delete();
      frame_on = 0;
    end else begin
      if (start && !busy) begin
        s_cyc    = cyc_n;
        frame_on = 1;
        en_cnt   = 0;
        w_exp    = w_mem;
        push_frame();
      end
      if (Weight_en) begin
        chk("wen_lat", 64'(cyc_n - s_cyc), 3);
        chk("w_lo", Weight[63:0], w_exp[63:0]);
        chk("w_hi", Weight[WW-1 -: 64], w_exp[WW-1 -: 64]);
      end
      if (en) begin
        en_cnt++;
        last_cyc = cyc_n;
        if (exp_q.size() == 0) begin
          chk("extra_en", 1, 0);
        end else begin
          b = exp_q.pop_front();
          chk("col", col, b.col);
          chk("row", row, b.row);
          chk("d1", Data1, b.d1);
          chk("d2", Data2, b.d2);
          chk("d3", Data3, b.d3);
          chk("rd_en", prev_rd, b.col != 0 && b.col != 9'(W + 1));
        end
      end
      if (done) begin
        chk("done_live", frame_on, 1);
        chk("done_lat", 64'(cyc_n - last_cyc), DC);
        chk("en_total", en_cnt, (W + 2) * H);
        done_cnt++;
        frame_on = 0;
      end
    end
    prev_rd = fm_rd_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WW-1:0] rand_w();
    logic [WW-1:0] v;
    for (int i = 0; i < WW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic out_any();
    return (|{en, col, row, Data1, Data2, Data3, Weight_en, fm_rd_en,
              fm_addr1, fm_addr2, fm_addr3, w_rd_en, busy, done})
           | (|Weight);
  endfunction

  task automatic kick();
    w_mem = rand_w();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int n = 0;
    while (!done && n < budget) begin
      if (rnd) ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    chk("frame_end", n < budget, 1);
    ready = 1'b1;
  endtask

  initial begin
    int n, sn;
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b1;
    w_mem = '0;
    repeat (2) tick();
    chk("rst_outs", out_any(), 0);
    rst = 1'b0;
    tick();

    // directed frame: 5-cycle stall at (2,1) and a stray start
    kick();
    n = 0;
    while (!(en && col == 9'd0 && row == 9'd1) && n < 100) begin
      tick();
      n++;
    end
    chk("stall_sync", n < 100, 1);
    tick();
    ready = 1'b0;
    sn = 0;
    repeat (5) begin
      tick();
      sn += int'(en);
    end
    ready = 1'b1;
    chk("stall_en", sn, 0);
    tick();
    chk("post_en", en, 1);
    chk("post_col", col, 2);
    chk("post_row", row, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(200, 0);
    repeat (4) tick();
    chk("idle_after", busy, 0);
    chk("done_one", done_cnt, 1);

    repeat (4) begin
      ready = $urandom_range(0, 1) != 0;
      kick();
      wait_done(400, 1);
      tick();
    end

    // abort in the 10th streaming cycle
    kick();
    repeat (11) tick();
    rst = 1'b1;
    tick();
    chk("abort_outs", out_any(), 0);
    rst = 1'b0;
    repeat (12) tick();
    chk("abort_idle", busy, 0);
    kick();
    wait_done(200, 0);
    tick();
    chk("done_cnt", done_cnt, 6);

    n = 0;
    while (!t_fin && n < 200) begin
      tick();
      n++;
    end
    chk("h1_finished", t_fin, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // single-pixel frame: three columns, no vertical neighbours
  initial begin
    int ec, dn;
    ec      = 0;
    dn      = 0;
    t_start = 1'b0;
    t_rst   = 1'b1;
    repeat (2) tick();
    t_rst = 1'b0;
    tick();
    t_start = 1'b1;
    tick();
    t_start = 1'b0;
    repeat (30) begin
      tick();
      if (t_en) begin
        chk("h1_col", t_col, ec);
        chk("h1_row", t_row, 0);
        chk("h1_d1", t_d1, px(-1, ec, 1, 1));
        chk("h1_d2", t_d2, px(0, ec, 1, 1));
        chk("h1_d3", t_d3, px(1, ec, 1, 1));
        ec++;
      end
      dn += int'(t_done);
    end
    chk("h1_en", ec, 3);
    chk("h1_done", dn, 1);
    t_fin = 1;
  end

endmodule
